alu_uart_ctrl: RTL and testbench

- Sequencing front/back end for the combinational ALU: collects operand A, operand B and op code as three consecutive bytes from the UART receiver.
- Drives the registered ALU inputs, captures the ALU result one cycle later, and hands it to the UART transmitter with a start/done handshake.
- Sits between uart_rx/uart_tx and the ALU in the board top level.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_op_check.sv | 34 +++
 rtl/alu_uart_ctrl.sv | 115 +++++++++++
 tb/tb_alu_uart_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing logic: default widths,
// supported op codes and the controller state encoding.
package alu_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    // Op codes understood by the combinational ALU
    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'd32;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'd34;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'd36;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'd37;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'd38;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'd39;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'd3;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'd4;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_CALC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

endpackage

// File: rtl/alu_op_check.sv
// Combinational op-byte validator: the byte is a valid op only when the
// bits above the op field are zero and the op field is a supported code.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] i_op_byte,
    output logic               o_valid
);

    logic [NB_OP-1:0] op_field;
    logic             upper_zero;
    logic             supported;

    assign op_field   = i_op_byte[NB_OP-1:0];
    assign upper_zero = (i_op_byte[NB_DATA-1:NB_OP] == '0);

    // Match the op field against the supported code set
    always_comb begin
        // NOTE: default first so every path assigns it; no latch is inferred.
        supported = 1'b0;
        if (op_field == NB_OP'(OP_ADD) || op_field == NB_OP'(OP_SUB) ||
            op_field == NB_OP'(OP_AND) || op_field == NB_OP'(OP_OR)  ||
            op_field == NB_OP'(OP_XOR) || op_field == NB_OP'(OP_NOR) ||
            op_field == NB_OP'(OP_SRA) || op_field == NB_OP'(OP_SRL)) begin
            supported = 1'b1;
        end
    end

    assign o_valid = upper_zero & supported;

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between the UART and the combinational ALU: gathers A, B and op
// bytes, presents registered operands, captures the result after one settle
// cycle and hands it to the transmitter with a start/done handshake.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_err,
    output logic               o_drop
);

    state_e             state_q;
    logic [NB_DATA-1:0] alu_a_q;
    logic [NB_DATA-1:0] alu_b_q;
    logic [NB_OP-1:0]   alu_op_q;
    logic [NB_DATA-1:0] tx_data_q;
    logic               tx_start_q;
    logic               err_q;
    logic               drop_q;
    logic               op_valid;

    alu_op_check #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_op_check (
        .i_op_byte (i_rx_data),
        .o_valid   (op_valid)
    );

    // Transaction FSM with registered operands, result and pulse outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        alu_a_q <= i_rx_data;
                        state_q <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        alu_b_q <= i_rx_data;
                        state_q <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        if (op_valid) begin
                            alu_op_q <= i_rx_data[NB_OP-1:0];
                            state_q  <= ST_CALC;
                        end else begin
                            // Operands are abandoned; next byte starts a new A
                            err_q   <= 1'b1;
                            state_q <= ST_WAIT_A;
                        end
                    end
                end
                ST_CALC: begin
                    drop_q    <= i_rx_done;
                    tx_data_q <= i_alu_result;
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    drop_q     <= i_rx_done;
                    tx_start_q <= 1'b1;
                    state_q    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    drop_q <= i_rx_done;
                    if (i_tx_done) begin
                        state_q <= ST_WAIT_A;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_err      = err_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: table of byte triples with
// hand-computed results, plus directed drop and mid-transmission reset cases.
module tb_alu_uart_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       err;
    logic       drop;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    int drop_cnt  = 0;
    int long_pulse = 0;
    logic start_prev = 1'b0;
    logic err_prev   = 1'b0;
    logic drop_prev  = 1'b0;

    alu_uart_ctrl #(
        .NB_DATA (8),
        .NB_OP   (6)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_done    (tx_done),
        .o_err        (err),
        .o_drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational ALU
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            6'd32: alu_result = alu_a + alu_b;
            6'd34: alu_result = alu_a - alu_b;
            6'd36: alu_result = alu_a & alu_b;
            6'd37: alu_result = alu_a | alu_b;
            6'd38: alu_result = alu_a ^ alu_b;
            6'd39: alu_result = ~(alu_a | alu_b);
            6'd3:  alu_result = 8'($signed(alu_a) >>> alu_b);
            6'd4:  alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    // Pulse counters and pulse-width watch, sampling pre-edge values
    always @(posedge clk) begin
        if (tx_start) start_cnt <= start_cnt + 1;
        if (err)      err_cnt   <= err_cnt + 1;
        if (drop)     drop_cnt  <= drop_cnt + 1;
        if ((tx_start && start_prev) || (err && err_prev) || (drop && drop_prev))
            long_pulse <= long_pulse + 1;
        start_prev <= tx_start;
        err_prev   <= err;
        drop_prev  <= drop;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing edge
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Starting just after the op-capture edge N: start pulse after N+2 only
    task automatic expect_tx(input string name, input logic [7:0] exp_tx);
        check({name, "_start_n0"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({name, "_start_n1"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({name, "_start_n2"}, 32'(tx_start), 32'd1);
        check({name, "_tx_data"}, 32'(tx_data), 32'(exp_tx));
        @(negedge clk);
        check({name, "_start_n3"}, 32'(tx_start), 32'd0);
        check({name, "_tx_hold"}, 32'(tx_data), 32'(exp_tx));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [5:0] exp_op;
        logic       exp_err;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int s0;
        vecs[0]  = '{8'h05, 8'h03, 8'h20, 6'd32, 1'b0, 8'h08}; // add
        vecs[1]  = '{8'h03, 8'h05, 8'h22, 6'd34, 1'b0, 8'hFE}; // sub wraps
        vecs[2]  = '{8'hF0, 8'h0F, 8'h27, 6'd39, 1'b0, 8'h00}; // nor
        vecs[3]  = '{8'h11, 8'h22, 8'h21, 6'd39, 1'b1, 8'h00}; // unsupported
        vecs[4]  = '{8'h01, 8'h01, 8'h24, 6'd36, 1'b0, 8'h01}; // and
        vecs[5]  = '{8'h05, 8'h03, 8'h60, 6'd36, 1'b1, 8'h00}; // upper bits set
        vecs[6]  = '{8'hC3, 8'h0F, 8'h26, 6'd38, 1'b0, 8'hCC}; // xor
        vecs[7]  = '{8'h80, 8'h02, 8'h03, 6'd3,  1'b0, 8'hE0}; // sra
        vecs[8]  = '{8'h80, 8'h02, 8'h04, 6'd4,  1'b0, 8'h20}; // srl
        vecs[9]  = '{8'h0A, 8'h05, 8'h25, 6'd37, 1'b0, 8'h0F}; // or
        vecs[10] = '{8'h55, 8'hAA, 8'h3F, 6'd37, 1'b1, 8'h00}; // 63 unsupported

        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_pulses", {29'd0, tx_start, err, drop}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // tx_done while idle must be ignored
        pulse_tx_done();

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            send_byte(vecs[i].op);
            check({nm, "_a"}, 32'(alu_a), 32'(vecs[i].a));
            check({nm, "_b"}, 32'(alu_b), 32'(vecs[i].b));
            check({nm, "_op"}, 32'(alu_op), 32'(vecs[i].exp_op));
            check({nm, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) begin
                s0 = start_cnt;
                @(negedge clk);
                check({nm, "_err_off"}, 32'(err), 32'd0);
                repeat (3) @(negedge clk);
                check({nm, "_no_start"}, 32'(start_cnt), 32'(s0));
            end else begin
                expect_tx(nm, vecs[i].exp_tx);
                pulse_tx_done();
            end
        end

        // Drops: byte in CALC, byte alone in WAIT_TX, byte together with tx_done
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        check("dropA_op", 32'(alu_op), 32'd32);
        rx_data = 8'h77; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("dropA_calc_drop", 32'(drop), 32'd1);
        check("dropA_start_n1", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("dropA_calc_drop_off", 32'(drop), 32'd0);
        check("dropA_start_n2", 32'(tx_start), 32'd1);
        check("dropA_tx", 32'(tx_data), 32'h08);
        @(negedge clk);
        send_byte(8'h99);
        check("dropA_wait_drop", 32'(drop), 32'd1);
        check("dropA_tx_hold", 32'(tx_data), 32'h08);
        @(negedge clk);
        check("dropA_wait_drop_off", 32'(drop), 32'd0);
        rx_data = 8'h66; rx_done = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; tx_done = 1'b0;
        check("dropA_both_drop", 32'(drop), 32'd1);
        check("dropA_both_tx_hold", 32'(tx_data), 32'h08);
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h20);
        check("dropB_a", 32'(alu_a), 32'h02);
        check("dropB_b", 32'(alu_b), 32'h02);
        expect_tx("dropB", 8'h04);
        pulse_tx_done();

        // Asynchronous reset during WAIT_TX aborts the transaction
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        expect_tx("rstB", 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("rstB_alu_a", 32'(alu_a), 32'd0);
        check("rstB_alu_b", 32'(alu_b), 32'd0);
        check("rstB_alu_op", 32'(alu_op), 32'd0);
        check("rstB_tx_data", 32'(tx_data), 32'd0);
        check("rstB_pulses", {29'd0, tx_start, err, drop}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        pulse_tx_done();
        repeat (4) @(negedge clk);
        check("rstB_no_start", 32'(start_cnt), 32'(s0));
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h04);
        check("rstC_a", 32'(alu_a), 32'h80);
        check("rstC_op", 32'(alu_op), 32'd4);
        expect_tx("rstC", 8'h40);
        pulse_tx_done();
        repeat (3) @(negedge clk);

        check("total_starts", 32'(start_cnt), 32'd12);
        check("total_errs", 32'(err_cnt), 32'd3);
        check("total_drops", 32'(drop_cnt), 32'd3);
        check("pulse_width", 32'(long_pulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
